// File: rtl/cont_updown_param.sv
// Parametrised up/down sweep counter: bounce (with endpoint dwell), wrap-up, wrap-down and hold.
// Optional synchronous load (ld/ld_val) exists only when the macro CONT_LOAD_EN is defined.
module cont_updown_param #(
    parameter int WIDTH = 4,
    parameter int MIN   = 0,            // 0 <= MIN < MAX
    parameter int MAX   = 2**WIDTH-1,   // MAX <= 2**WIDTH-1
    parameter int STEP  = 1,            // 1 <= STEP <= MAX-MIN
    parameter int DWELL = 1             // 0..255, bounce mode only
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
`ifdef CONT_LOAD_EN
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
`endif
    output logic [WIDTH-1:0] s,
    output logic             dir,
    output logic             at_end,
    output logic             dwelling
);

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_DWELL = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        M_BOUNCE  = 2'b00,
        M_WRAP_UP = 2'b01,
        M_WRAP_DN = 2'b10,
        M_HOLD    = 2'b11
    } mode_e;

    localparam int W1 = WIDTH + 1;

    // Limits carried one bit wider so overshoot past 2**WIDTH-1 is visible, never aliased.
    localparam logic [WIDTH:0]   MIN_X      = W1'(MIN);
    localparam logic [WIDTH:0]   MAX_X      = W1'(MAX);
    localparam logic [WIDTH:0]   STEP_X     = W1'(STEP);
    localparam logic [WIDTH:0]   LO_REACH_X = W1'(MIN + STEP);
    localparam logic [WIDTH-1:0] MIN_S      = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_S      = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] STEP_S     = WIDTH'(STEP);
    localparam logic [7:0]       DWELL_C    = 8'(DWELL);
    localparam logic             DWELL_ON   = (DWELL > 0);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             dir_q, dir_d;
    logic             at_end_q, at_end_d;
    logic             dwelling_q, dwelling_d;

    mode_e            mode_w;
    logic             load_w;
    logic [WIDTH-1:0] load_s_w;
    logic [WIDTH:0]   s_x;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] dn_diff;
    logic             hit_hi;
    logic             hit_lo;
    logic             wrap_over;
    logic             wrap_under;
    logic             dwell_last;

    assign mode_w = mode_e'(mode);

`ifdef CONT_LOAD_EN
    logic [WIDTH:0]   ld_x;
    logic [WIDTH-1:0] ld_hi_clamped;

    assign load_w        = ld;
    assign ld_x          = {1'b0, ld_val};
    assign ld_hi_clamped = (ld_x > MAX_X) ? MAX_S : ld_val;

    if (MIN > 0) begin : g_ld_lo_clamp
        assign load_s_w = (ld_x < MIN_X) ? MIN_S : ld_hi_clamped;
    end else begin : g_ld_no_lo_clamp
        assign load_s_w = ld_hi_clamped;
    end
`else
    assign load_w   = 1'b0;
    assign load_s_w = MIN_S;
`endif

    assign s_x        = {1'b0, s_q};
    assign up_sum     = s_x + STEP_X;
    // Only consumed when s >= MIN+STEP, so the narrow subtraction cannot wrap.
    assign dn_diff    = s_q - STEP_S;
    assign hit_hi     = (up_sum >= MAX_X);
    assign hit_lo     = (s_x <= LO_REACH_X);
    assign wrap_over  = (up_sum > MAX_X);
    assign wrap_under = (s_x < LO_REACH_X);
    assign dwell_last = (cnt_q == 8'd1);

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_COUNT;
            cnt_q      <= '0;
            s_q        <= MIN_S;
            dir_q      <= 1'b0;
            at_end_q   <= 1'b0;
            dwelling_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            dir_q      <= dir_d;
            at_end_q   <= at_end_d;
            dwelling_q <= dwelling_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load_w) begin
            state_d = ST_COUNT;
            cnt_d   = '0;
        end else if (en) begin
            case (mode_w)
                M_BOUNCE: begin
                    if (state_q == ST_DWELL) begin
                        cnt_d = cnt_q - 8'd1;
                        if (dwell_last) state_d = ST_COUNT;
                    end else if (DWELL_ON && (dir_q ? hit_lo : hit_hi)) begin
                        state_d = ST_DWELL;
                        cnt_d   = DWELL_C;
                    end
                end
                M_WRAP_UP, M_WRAP_DN: begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                end
                default: ;
            endcase
        end
    end

    // Hold mode and en=0 freeze everything except at_end, which only pulses on arrival.
    always_comb begin
        s_d        = s_q;
        dir_d      = dir_q;
        at_end_d   = 1'b0;
        dwelling_d = dwelling_q;
        if (load_w) begin
            s_d        = load_s_w;
            dwelling_d = 1'b0;
        end else if (en) begin
            case (mode_w)
                M_BOUNCE: begin
                    if (state_q == ST_DWELL) begin
                        dwelling_d = 1'b1;
                    end else begin
                        dwelling_d = 1'b0;
                        if (!dir_q) begin
                            if (hit_hi) begin
                                s_d      = MAX_S;
                                at_end_d = 1'b1;
                                dir_d    = 1'b1;
                            end else begin
                                s_d = up_sum[WIDTH-1:0];
                            end
                        end else begin
                            if (hit_lo) begin
                                s_d      = MIN_S;
                                at_end_d = 1'b1;
                                dir_d    = 1'b0;
                            end else begin
                                s_d = dn_diff;
                            end
                        end
                    end
                end
                M_WRAP_UP: begin
                    dwelling_d = 1'b0;
                    dir_d      = 1'b0;
                    s_d        = wrap_over ? MIN_S : up_sum[WIDTH-1:0];
                    at_end_d   = (up_sum == MAX_X);
                end
                M_WRAP_DN: begin
                    dwelling_d = 1'b0;
                    dir_d      = 1'b1;
                    s_d        = wrap_under ? MAX_S : dn_diff;
                    at_end_d   = (s_x == LO_REACH_X);
                end
                default: ;
            endcase
        end
    end

    assign s        = s_q;
    assign dir      = dir_q;
    assign at_end   = at_end_q;
    assign dwelling = dwelling_q;

endmodule

// File: tb/tb_cont_updown_param.sv
// Bench for cont_updown_param: four parameter sets run side by side against an arithmetic
// reference model, plus a table of the default sweep and hand-written corner sequences.
`timescale 1ns/1ps
module tb_cont_updown_param;

    typedef struct {
        string nm;
        int    w;
        int    mn;
        int    mx;
        int    step;
        int    dwell;
    } cfg_t;

    typedef struct {
        int s;
        bit dir;
        bit at_end;
        bit dwelling;
        int left;     // remaining hold cycles at an endpoint
    } mdl_t;

    typedef struct {
        bit       en;
        bit [1:0] mode;
        int       s;
        bit       dir;
        bit       at_end;
        bit       dwelling;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       ld;
    logic [3:0] ld_val;

    logic [3:0] s_def, s_mm, s_d3;
    logic [2:0] s_w3;
    logic [3:0] dir_v, end_v, dw_v;

    cfg_t cfg [4];
    mdl_t mdl [4];
    vec_t vecs [$];
    int   w3_exp [$];
    int   mm_exp [$];
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cont_updown_param u_def (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef CONT_LOAD_EN
        .ld(ld), .ld_val(ld_val),
`endif
        .s(s_def), .dir(dir_v[0]), .at_end(end_v[0]), .dwelling(dw_v[0]));

    cont_updown_param #(.WIDTH(3), .DWELL(0)) u_w3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef CONT_LOAD_EN
        .ld(ld), .ld_val(ld_val[2:0]),
`endif
        .s(s_w3), .dir(dir_v[1]), .at_end(end_v[1]), .dwelling(dw_v[1]));

    cont_updown_param #(.MIN(2), .MAX(10), .STEP(3), .DWELL(1)) u_mm (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef CONT_LOAD_EN
        .ld(ld), .ld_val(ld_val),
`endif
        .s(s_mm), .dir(dir_v[2]), .at_end(end_v[2]), .dwelling(dw_v[2]));

    cont_updown_param #(.DWELL(3)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef CONT_LOAD_EN
        .ld(ld), .ld_val(ld_val),
`endif
        .s(s_d3), .dir(dir_v[3]), .at_end(end_v[3]), .dwelling(dw_v[3]));

    function automatic cfg_t mk_cfg(string nm, int w, int mn, int mx, int step, int dwell);
        cfg_t c;
        c.nm = nm; c.w = w; c.mn = mn; c.mx = mx; c.step = step; c.dwell = dwell;
        return c;
    endfunction

    function automatic vec_t mk_vec(int s, bit dir, bit at_end, bit dwelling);
        vec_t v;
        v.en = 1'b1; v.mode = 2'b00;
        v.s = s; v.dir = dir; v.at_end = at_end; v.dwelling = dwelling;
        return v;
    endfunction

    function automatic mdl_t reset_m(cfg_t c);
        mdl_t m;
        m.s = c.mn; m.dir = 1'b0; m.at_end = 1'b0; m.dwelling = 1'b0; m.left = 0;
        return m;
    endfunction

    // One enabled edge of the counter, computed from the behavioural rules with plain integers.
    function automatic mdl_t step_m(cfg_t c, mdl_t m, bit e, int md, bit l, int lv);
        int n;
        if (l) begin
            lv = lv % (1 << c.w);
            m.s = (lv < c.mn) ? c.mn : ((lv > c.mx) ? c.mx : lv);
            m.at_end = 1'b0; m.dwelling = 1'b0; m.left = 0;
            return m;
        end
        m.at_end = 1'b0;
        if (!e || md == 3) return m;
        if (md == 1) begin
            m.dir = 1'b0; m.dwelling = 1'b0; m.left = 0;
            n = m.s + c.step;
            m.s = (n > c.mx) ? c.mn : n;
            m.at_end = (m.s == c.mx);
            return m;
        end
        if (md == 2) begin
            m.dir = 1'b1; m.dwelling = 1'b0; m.left = 0;
            n = m.s - c.step;
            m.s = (n < c.mn) ? c.mx : n;
            m.at_end = (m.s == c.mn);
            return m;
        end
        if (m.left > 0) begin
            m.left--;
            m.dwelling = 1'b1;
            return m;
        end
        m.dwelling = 1'b0;
        n = m.dir ? m.s - c.step : m.s + c.step;
        if (!m.dir && n >= c.mx) begin
            m.s = c.mx; m.at_end = 1'b1; m.dir = 1'b1; m.left = c.dwell;
        end else if (m.dir && n <= c.mn) begin
            m.s = c.mn; m.at_end = 1'b1; m.dir = 1'b0; m.left = c.dwell;
        end else begin
            m.s = n;
        end
        return m;
    endfunction

    function automatic int dut_s(int i);
        case (i)
            0:       return int'(s_def);
            1:       return int'(s_w3);
            2:       return int'(s_mm);
            default: return int'(s_d3);
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 4; i++) begin
            check({cfg[i].nm, ".s"},        dut_s(i),         mdl[i].s);
            check({cfg[i].nm, ".dir"},      int'(dir_v[i]),   int'(mdl[i].dir));
            check({cfg[i].nm, ".at_end"},   int'(end_v[i]),   int'(mdl[i].at_end));
            check({cfg[i].nm, ".dwelling"}, int'(dw_v[i]),    int'(mdl[i].dwelling));
        end
    endtask

    // Advance one clock: the model consumes the inputs present at the edge, outputs compared 1ns later.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rst) mdl[i] = reset_m(cfg[i]);
            else     mdl[i] = step_m(cfg[i], mdl[i], en, int'(mode), ld, int'(ld_val));
        end
        #1;
        compare_all();
    endtask

    task automatic check_d3(string name, int s_exp, int dw_exp, int end_exp);
        check({name, ".s"},        int'(s_d3),     s_exp);
        check({name, ".dwelling"}, int'(dw_v[3]),  dw_exp);
        check({name, ".at_end"},   int'(end_v[3]), end_exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        n_checks = 0;
        n_fail   = 0;
        cfg[0] = mk_cfg("def", 4, 0, 15, 1, 1);
        cfg[1] = mk_cfg("w3",  3, 0, 7,  1, 0);
        cfg[2] = mk_cfg("mm",  4, 2, 10, 3, 1);
        cfg[3] = mk_cfg("d3",  4, 0, 15, 1, 3);

        // Default sweep from reset: up to 15, dwell, down to 0, dwell, step up.
        for (int v = 1; v <= 15; v++) vecs.push_back(mk_vec(v, v == 15, v == 15, 1'b0));
        vecs.push_back(mk_vec(15, 1'b1, 1'b0, 1'b1));
        for (int v = 14; v >= 0; v--) vecs.push_back(mk_vec(v, v != 0, v == 0, 1'b0));
        vecs.push_back(mk_vec(0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk_vec(1, 1'b0, 1'b0, 1'b0));
        w3_exp = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        mm_exp = '{5, 8, 10, 10, 7, 4, 2, 2, 5};

        rst = 1'b1; en = 1'b0; mode = 2'b00; ld = 1'b0; ld_val = '0;
        for (int i = 0; i < 4; i++) mdl[i] = reset_m(cfg[i]);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            en   = vecs[i].en;
            mode = vecs[i].mode;
            tick();
            check($sformatf("tbl[%0d].s", i),        int'(s_def),    vecs[i].s);
            check($sformatf("tbl[%0d].dir", i),      int'(dir_v[0]), int'(vecs[i].dir));
            check($sformatf("tbl[%0d].at_end", i),   int'(end_v[0]), int'(vecs[i].at_end));
            check($sformatf("tbl[%0d].dwelling", i), int'(dw_v[0]),  int'(vecs[i].dwelling));
            if (i < w3_exp.size()) check($sformatf("w3seq[%0d]", i), int'(s_w3), w3_exp[i]);
            if (i < mm_exp.size()) check($sformatf("mmseq[%0d]", i), int'(s_mm), mm_exp[i]);
        end

        // Wrap-up through the top, then wrap-down through the bottom.
        mode  = 2'b01;
        guard = 0;
        while (s_def != 4'd14 && guard < 20) begin
            tick();
            guard++;
        end
        check("wrap_up.reach14", int'(s_def), 14);
        tick(); check("wrap_up.s15", int'(s_def), 15); check("wrap_up.end15", int'(end_v[0]), 1);
        check("wrap_up.dir", int'(dir_v[0]), 0);
        tick(); check("wrap_up.s0", int'(s_def), 0);   check("wrap_up.end0", int'(end_v[0]), 0);
        tick(); check("wrap_up.s1", int'(s_def), 1);
        mode = 2'b10;
        tick(); check("wrap_dn.s0", int'(s_def), 0);   check("wrap_dn.end0", int'(end_v[0]), 1);
        check("wrap_dn.dir", int'(dir_v[0]), 1);
        tick(); check("wrap_dn.s15", int'(s_def), 15); check("wrap_dn.end15", int'(end_v[0]), 0);
        tick(); check("wrap_dn.s14", int'(s_def), 14);

        // Freeze in the middle of a three-cycle dwell, then async reset mid-descent.
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; mode = 2'b00;
        repeat (15) tick();
        check_d3("d3.arrive", 15, 0, 1);
        tick();
        check_d3("d3.dwell1", 15, 1, 0);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_d3($sformatf("d3.frozen%0d", k), 15, 1, 0);
        end
        en = 1'b1;
        tick(); check_d3("d3.dwell2", 15, 1, 0);
        tick(); check_d3("d3.dwell3", 15, 1, 0);
        tick(); check_d3("d3.leave", 14, 0, 0);
        repeat (5) tick();
        check("d3.at9", int'(s_d3), 9);
        #3;
        rst = 1'b1;
        #1;
        check("d3.async_rst.s", int'(s_d3), 0);
        check("d3.async_rst.dir", int'(dir_v[3]), 0);
        for (int i = 0; i < 4; i++) mdl[i] = reset_m(cfg[i]);
        compare_all();
        #2;
        rst = 1'b0;
        tick();
        check("d3.resume", int'(s_d3), 1);

`ifdef CONT_LOAD_EN
        en = 1'b0; ld = 1'b1; ld_val = 4'd12;
        tick();
        ld = 1'b0;
        check("ld.clamp_hi", int'(s_mm), 10);
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; mode = 2'b00;
        tick(); tick(); tick();
        check("ld.pre_s", int'(s_mm), 10);
        check("ld.pre_dir", int'(dir_v[2]), 1);
        ld = 1'b1; ld_val = 4'd5;
        tick();
        ld = 1'b0;
        check("ld.dwell_s", int'(s_mm), 5);
        check("ld.dwell_dwelling", int'(dw_v[2]), 0);
        check("ld.dwell_dir", int'(dir_v[2]), 1);
        tick();
        check("ld.after_s", int'(s_mm), 2);
`endif

        // Random phase: all four configurations compared against the model on every edge.
        for (int k = 0; k < 800; k++) begin
            int r;
            r    = $urandom_range(0, 9);
            mode = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            en   = ($urandom_range(0, 9) != 0);
`ifdef CONT_LOAD_EN
            ld     = ($urandom_range(0, 19) == 0);
            ld_val = 4'($urandom_range(0, 15));
`else
            ld     = 1'b0;
            ld_val = '0;
`endif
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        ld  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
